// File: rtl/jtopl_acc_multi_if.sv
// Operator-side sample bus into the stereo accumulator plus its registered stereo output.
// The master drives operator data and clock enable; the slave returns samples and strobes.
interface jtopl_acc_multi_if #(
  parameter int W_IN  = 13,
  parameter int W_OUT = 16,
  parameter int SLOTS = 18
);
  logic                    cenop;
  logic signed [W_IN-1:0]  op_result;
  logic [SLOTS-1:0]        slot;
  logic                    rhy_en;
  logic                    zero;
  logic                    op;
  logic                    con;
  logic                    pan_l;
  logic                    pan_r;
  logic signed [W_OUT-1:0] snd_l;
  logic signed [W_OUT-1:0] snd_r;
  logic                    snd_vld;
  logic                    clip;

  modport master (
    output cenop, op_result, slot, rhy_en, zero, op, con, pan_l, pan_r,
    input  snd_l, snd_r, snd_vld, clip
  );

  modport slave (
    input  cenop, op_result, slot, rhy_en, zero, op, con, pan_l, pan_r,
    output snd_l, snd_r, snd_vld, clip
  );
endinterface

// File: rtl/jtopl_acc_multi.sv
// Stereo per-frame operator accumulator with rhythm gain, pan gating and output saturation.
// Frame N appears on snd_l/snd_r one cenop edge after zero of frame N+1; cenop low freezes everything.
module jtopl_acc_multi #(
  parameter int               W_IN      = 13,
  parameter int               W_OUT     = 16,
  parameter int               SLOTS     = 18,
  parameter logic [SLOTS-1:0] RHY_MASK  = 18'h000FC,
  parameter int               RHY_SHIFT = 1
) (
  input logic              clk,
  input logic              rst_n,
  jtopl_acc_multi_if.slave bus
);
  localparam int W_ACC = W_IN + RHY_SHIFT + $clog2(SLOTS) + 1;
  // Comparison width is wide enough to hold both the accumulator and the output limits.
  localparam int W_CMP = ((W_ACC > W_OUT) ? W_ACC : W_OUT) + 1;
  localparam logic signed [W_CMP-1:0] SAT_MAX = (W_CMP'(1) <<< (W_OUT - 1)) - W_CMP'(1);
  localparam logic signed [W_CMP-1:0] SAT_MIN = -(W_CMP'(1) <<< (W_OUT - 1));

  logic signed [W_ACC-1:0] acc_q [2];
  logic signed [W_ACC-1:0] acc_d [2];
  logic signed [W_OUT-1:0] snd_q [2];
  logic signed [W_OUT-1:0] snd_d [2];
  logic [W_OUT:0]          sat_w [2];
  logic                    vld_q, vld_d;
  logic                    clip_q, clip_d;
  logic signed [W_ACC-1:0] term_ext;
  logic signed [W_ACC-1:0] term;
  logic [1:0]              pan;
  logic [1:0]              ovf;
  logic                    rhy_hit;
  logic                    contrib;
  logic                    latch;

  // Returns {overflow, clamped sample}.
  function automatic logic [W_OUT:0] saturate(input logic signed [W_ACC-1:0] a);
    logic signed [W_CMP-1:0] e;
    e = W_CMP'(a);
    if (e > SAT_MAX)      saturate = {1'b1, W_OUT'(SAT_MAX)};
    else if (e < SAT_MIN) saturate = {1'b1, W_OUT'(SAT_MIN)};
    else                  saturate = {1'b0, W_OUT'(e)};
  endfunction

  always_comb begin
    rhy_hit  = bus.rhy_en && (|(bus.slot & RHY_MASK));
    term_ext = W_ACC'(bus.op_result);
    term     = rhy_hit ? (term_ext <<< RHY_SHIFT) : term_ext;
    contrib  = bus.op | bus.con;
    pan      = {bus.pan_r, bus.pan_l};
    latch    = bus.cenop && bus.zero;
    ovf      = '0;
    for (int c = 0; c < 2; c++) begin
      acc_d[c] = acc_q[c];
      snd_d[c] = snd_q[c];
      sat_w[c] = saturate(acc_q[c]);
      ovf[c]   = sat_w[c][W_OUT];
      // zero restarts the frame: the current slot seeds the accumulator.
      if (bus.cenop) begin
        acc_d[c] = (bus.zero ? W_ACC'(0) : acc_q[c]) +
                   ((contrib && pan[c]) ? term : W_ACC'(0));
      end
      if (latch) begin
        snd_d[c] = sat_w[c][W_OUT-1:0];
      end
    end
    vld_d  = latch;
    clip_d = latch && (|ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        acc_q[c] <= '0;
        snd_q[c] <= '0;
      end
      vld_q  <= 1'b0;
      clip_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        acc_q[c] <= acc_d[c];
        snd_q[c] <= snd_d[c];
      end
      vld_q  <= vld_d;
      clip_q <= clip_d;
    end
  end

  assign bus.snd_l   = snd_q[0];
  assign bus.snd_r   = snd_q[1];
  assign bus.snd_vld = vld_q;
  assign bus.clip    = clip_q;
endmodule

// File: tb/tb_jtopl_acc_multi.sv
// Directed bench for jtopl_acc_multi: one instance at W_OUT=16, one at W_OUT=13, same stimulus.
module tb_jtopl_acc_multi;
  localparam logic [17:0] ALL = 18'h3FFFF;

  typedef struct {
    int          val;
    logic [17:0] dmask;
    logic [17:0] opm;
    logic [17:0] conm;
    logic [17:0] plm;
    logic [17:0] prm;
    bit          rhy;
    int          el16, er16, el13, er13;
    bit          c16, c13;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cenop, rhy_en, zero, op, con, pan_l, pan_r;
  logic signed [12:0] op_result;
  logic [17:0]        slot;

  int   n_chk = 0;
  int   n_err = 0;
  vec_t tbl [11];
  vec_t z, v10, prev;

  always #5 clk = ~clk;

  jtopl_acc_multi_if #(.W_IN(13), .W_OUT(16), .SLOTS(18)) if16 ();
  jtopl_acc_multi_if #(.W_IN(13), .W_OUT(13), .SLOTS(18)) if13 ();

  assign if16.cenop = cenop;  assign if13.cenop = cenop;
  assign if16.op_result = op_result;  assign if13.op_result = op_result;
  assign if16.slot = slot;    assign if13.slot = slot;
  assign if16.rhy_en = rhy_en; assign if13.rhy_en = rhy_en;
  assign if16.zero = zero;    assign if13.zero = zero;
  assign if16.op = op;        assign if13.op = op;
  assign if16.con = con;      assign if13.con = con;
  assign if16.pan_l = pan_l;  assign if13.pan_l = pan_l;
  assign if16.pan_r = pan_r;  assign if13.pan_r = pan_r;

  jtopl_acc_multi #(.W_OUT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  jtopl_acc_multi #(.W_OUT(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(if13.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_latch(input string tag, input vec_t e);
    chk({tag, " l16"}, int'(if16.snd_l), e.el16);
    chk({tag, " r16"}, int'(if16.snd_r), e.er16);
    chk({tag, " vld16"}, int'(if16.snd_vld), 1);
    chk({tag, " clip16"}, int'(if16.clip), int'(e.c16));
    chk({tag, " l13"}, int'(if13.snd_l), e.el13);
    chk({tag, " r13"}, int'(if13.snd_r), e.er13);
    chk({tag, " vld13"}, int'(if13.snd_vld), 1);
    chk({tag, " clip13"}, int'(if13.clip), int'(e.c13));
  endtask

  task automatic drive_slot(input int s, input vec_t v);
    cenop     = 1'b1;
    slot      = 18'h1 << s;
    zero      = (s == 0);
    op_result = v.dmask[s] ? 13'(v.val) : 13'sd0;
    op        = v.opm[s];
    con       = v.conm[s];
    pan_l     = v.plm[s];
    pan_r     = v.prm[s];
    rhy_en    = v.rhy;
  endtask

  // Runs one 18-slot frame of v; the opening zero latches the previous frame, expected as e.
  task automatic run_frame(input vec_t v, input vec_t e, input int stall_at, input string tag);
    for (int s = 0; s < 18; s++) begin
      if (s == stall_at) begin
        for (int k = 0; k < 5; k++) begin
          cenop     = 1'b0;
          zero      = (k % 2 == 0);
          op_result = 13'($urandom_range(0, 4095));
          op = 1'b1; pan_l = 1'b1; pan_r = 1'b1;
          tick();
          chk({tag, " stall vld16"}, int'(if16.snd_vld), 0);
          chk({tag, " stall vld13"}, int'(if13.snd_vld), 0);
          chk({tag, " stall hold l16"}, int'(if16.snd_l), e.el16);
        end
      end
      drive_slot(s, v);
      tick();
      if (s == 0) chk_latch(tag, e);
      if (s == 1) begin
        chk({tag, " vld16 drop"}, int'(if16.snd_vld), 0);
        chk({tag, " vld13 drop"}, int'(if13.snd_vld), 0);
      end
    end
  endtask

  initial begin
    z   = '{0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0};
    v10 = '{10, ALL, ALL, 18'h0, ALL, ALL, 1'b0, 180, 180, 180, 180, 1'b0, 1'b0};
    // basic sum, rhythm on/off, pan/op and con gating
    tbl[0]  = '{100, ALL, ALL, 18'h0, ALL, ALL, 1'b0, 1800, 1800, 1800, 1800, 1'b0, 1'b0};
    tbl[1]  = '{100, 18'h4, ALL, 18'h0, ALL, ALL, 1'b1, 200, 200, 200, 200, 1'b0, 1'b0};
    tbl[2]  = '{100, 18'h4, ALL, 18'h0, ALL, ALL, 1'b0, 100, 100, 100, 100, 1'b0, 1'b0};
    tbl[3]  = '{50, ALL, 18'h001FF, 18'h0, ALL, 18'h0, 1'b0, 450, 0, 450, 0, 1'b0, 1'b0};
    tbl[4]  = '{50, ALL, 18'h0, 18'h3FE00, 18'h0, ALL, 1'b0, 0, 450, 0, 450, 1'b0, 1'b0};
    // saturation: 12*4095 + 6*8190 = 98280, 24*-4096 = -98304, 24*-300 = -7200
    tbl[5]  = '{4095, ALL, ALL, 18'h0, ALL, ALL, 1'b1, 32767, 32767, 4095, 4095, 1'b1, 1'b1};
    tbl[6]  = '{-4096, ALL, ALL, 18'h0, ALL, ALL, 1'b1, -32768, -32768, -4096, -4096, 1'b1, 1'b1};
    tbl[7]  = '{-300, ALL, ALL, 18'h0, ALL, 18'h0, 1'b1, -7200, 0, -4096, 0, 1'b0, 1'b1};
    // exact limits of the 13-bit output and one step beyond
    tbl[8]  = '{4095, 18'h1, ALL, 18'h0, ALL, ALL, 1'b1, 4095, 4095, 4095, 4095, 1'b0, 1'b0};
    tbl[9]  = '{2048, 18'h4, ALL, 18'h0, ALL, ALL, 1'b1, 4096, 4096, 4095, 4095, 1'b0, 1'b1};
    tbl[10] = '{-4096, 18'h1, ALL, 18'h0, ALL, ALL, 1'b0, -4096, -4096, -4096, -4096, 1'b0, 1'b0};

    rst_n = 1'b0;
    cenop = 1'b0; zero = 1'b0; slot = 18'h0; op_result = 13'sd0;
    op = 1'b0; con = 1'b0; pan_l = 1'b0; pan_r = 1'b0; rhy_en = 1'b0;
    tick(); tick();
    chk("reset l16", int'(if16.snd_l), 0);
    chk("reset r16", int'(if16.snd_r), 0);
    chk("reset vld16", int'(if16.snd_vld), 0);
    chk("reset clip16", int'(if16.clip), 0);
    chk("reset l13", int'(if13.snd_l), 0);
    #2 rst_n = 1'b1;

    // running without zero must not strobe
    for (int k = 0; k < 3; k++) begin
      cenop = 1'b1; zero = 1'b0; slot = 18'h1 << k; op_result = 13'sd77;
      tick();
      chk("pre-zero vld16", int'(if16.snd_vld), 0);
      chk("pre-zero vld13", int'(if13.snd_vld), 0);
    end

    prev = z;
    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i], prev, -1, $sformatf("v%0d", i));
      prev = tbl[i];
    end
    run_frame(z, prev, -1, "flush");

    // five stalled cycles between slot 8 and slot 9
    run_frame(v10, z, 9, "stall");
    run_frame(z, v10, -1, "stall sum");

    // zero on consecutive cenop cycles: one-slot frames
    cenop = 1'b1; zero = 1'b1; op = 1'b1; con = 1'b0; pan_l = 1'b1; pan_r = 1'b1; rhy_en = 1'b0;
    slot = 18'h1; op_result = 13'sd7;
    tick();
    chk("czero a l16", int'(if16.snd_l), 0);
    chk("czero a vld16", int'(if16.snd_vld), 1);
    slot = 18'h2; op_result = 13'sd9;
    tick();
    chk("czero b l16", int'(if16.snd_l), 7);
    chk("czero b r13", int'(if13.snd_r), 7);
    chk("czero b vld16", int'(if16.snd_vld), 1);
    slot = 18'h4; op_result = 13'sd5;
    tick();
    chk("czero c l16", int'(if16.snd_l), 9);
    chk("czero c r13", int'(if13.snd_r), 9);
    chk("czero c vld13", int'(if13.snd_vld), 1);
    cenop = 1'b0;
    tick();
    chk("czero idle vld16", int'(if16.snd_vld), 0);
    chk("czero idle hold l16", int'(if16.snd_l), 9);

    // reset after slot 8 of a +10 frame discards the partial sum
    for (int s = 0; s < 9; s++) begin
      drive_slot(s, v10);
      tick();
      if (s == 0) chk("pre-reset l16", int'(if16.snd_l), 5);
    end
    cenop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset l16", int'(if16.snd_l), 0);
    chk("async reset r13", int'(if13.snd_r), 0);
    chk("async reset vld16", int'(if16.snd_vld), 0);
    #3 rst_n = 1'b1;
    tick();
    run_frame(v10, z, -1, "rst first");
    run_frame(z, v10, -1, "rst second");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/jtopl_acc_multi.md
JTOPL_ACC_MULTI -- requirements
Module: jtopl_acc_multi

Interface
REQ-001 SHALL provide parameter W_IN, default 13, signed operator sample width.
REQ-002 SHALL provide parameter W_OUT, default 16, signed output sample width; W_OUT >= W_IN required.
REQ-003 SHALL provide parameter SLOTS, default 18, number of operator slots per sample frame; slot bus width.
REQ-004 SHALL provide parameter RHY_MASK, default 18'h000FC, slot bits whose data receives rhythm gain, covering data-path latency.
REQ-005 SHALL provide parameter RHY_SHIFT, default 1, left-shift applied to rhythm slot data (x2).
REQ-006 SHALL provide port clk, input, 1, system clock.
REQ-007 SHALL provide port rst_n, input, 1, reset; one clock, asynchronous, active-low.
REQ-008 SHALL provide port cenop, input, 1, operator clock enable; all state advances only when high.
REQ-009 SHALL provide port op_result, input, W_IN signed, operator output for the current slot.
REQ-010 SHALL provide port slot, input, SLOTS, one-hot current slot.
REQ-011 SHALL provide port rhy_en, input, 1, rhythm mode enable.
REQ-012 SHALL provide port zero, input, 1, first slot of a new sample frame.
REQ-013 SHALL provide ports op and con, input, 1 each; slot contributes when op|con.
REQ-014 SHALL provide ports pan_l and pan_r, input, 1 each, route current slot to left/right.
REQ-015 SHALL provide ports snd_l and snd_r, output, W_OUT signed, registered stereo samples.
REQ-016 SHALL provide port snd_vld, output, 1, one-cycle strobe when snd_l/snd_r update.
REQ-017 SHALL provide port clip, output, 1, one-cycle strobe when either channel saturated at update.

Function
REQ-018 SHALL form term = op_result sign-extended, shifted left by RHY_SHIFT when rhy_en && |(slot & RHY_MASK), else unshifted.
REQ-019 SHALL gate term to zero per channel unless (op|con) and the channel's pan bit is set.
REQ-020 SHALL hold two internal signed accumulators of width W_IN+RHY_SHIFT+clog2(SLOTS)+1; accumulators never wrap within one frame.
REQ-021 SHALL, on cenop && !zero, add gated term to each accumulator.
REQ-022 SHALL, on cenop && zero, load each accumulator with its gated term (new frame) and simultaneously latch the previous accumulator value, saturated to W_OUT, into snd_l/snd_r.
REQ-023 SHALL saturate to +(2^(W_OUT-1)-1) / -(2^(W_OUT-1)) and assert clip in the same cycle as snd_vld if either channel clipped.
REQ-024 SHALL pulse snd_vld high for exactly one clk cycle, the cycle after the latching edge; low otherwise, including when cenop is low.
REQ-025 SHALL ignore all inputs when cenop is low; state and outputs hold.
REQ-026 SHALL treat zero asserted on consecutive cenop cycles as consecutive one-slot frames (each latches).
REQ-027 SHALL have latency: snd reflects frame N one cenop-qualified edge after zero of frame N+1.
REQ-028 SHALL not require slot one-hot for correctness of accumulation; only the rhythm gain decision uses slot.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear both accumulators, snd_l, snd_r, snd_vld and clip to 0.
REQ-030 SHALL, after rst_n release, produce no snd_vld until the first cenop && zero; the first latched sample is 0 plus nothing carried from pre-reset state.
REQ-031 SHALL discard a partially accumulated frame if reset asserts mid-frame.

Verification
REQ-032 Basic sum: 18 slots, cenop every cycle, op=1, op_result=+100, pan_l=pan_r=1, rhy_en=0 -> next zero latches snd_l=snd_r=1800, snd_vld one cycle, clip=0.
REQ-033 Rhythm gain: rhy_en=1, op_result=+100 on slot bit 2 only, other slots 0 -> snd=200; same with rhy_en=0 -> snd=100.
REQ-034 Panning/con gating: op_result=+50 all slots, op=0 con=0 on 9 slots, pan_r=0 throughout -> snd_l=450, snd_r=0.
REQ-035 Saturation: W_OUT=13, 18 slots of +4095 with rhythm on 6 slots -> snd=+4095, clip=1; all -4096 -> snd=-4096, clip=1.
REQ-036 cenop gating: cenop low for 5 cycles mid-frame with op_result changing -> final sum unchanged vs. no-stall run; snd_vld never asserted while stalled.
REQ-037 Reset mid-frame: assert rst_n=0 after slot 9, release, run a full frame of +10 -> first latched snd=0, second latched snd=180.
